// File: rtl/dut_host_pkg.sv
// Shared types and DUT register map for the host-side sequencer.
package dut_host_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_POLL_A, S_CHK_A, S_WR_A, S_POLL_B, S_CHK_B, S_WR_B,
    S_POLL_Y, S_CHK_Y, S_RD_Y, S_CAP_Y, S_OUT
  } state_e;

  localparam int ADDR_A_NF = 0;
  localparam int ADDR_B_NF = 1;
  localparam int ADDR_Y_NE = 2;
  localparam int ADDR_Y_RD = 3;
  localparam int ADDR_A_WR = 4;
  localparam int ADDR_B_WR = 5;

  function automatic state_e chk_hit(input state_e s);
    case (s)
      S_CHK_A: return S_WR_A;
      S_CHK_B: return S_WR_B;
      default: return S_RD_Y;
    endcase
  endfunction

  function automatic state_e chk_retry(input state_e s);
    case (s)
      S_CHK_A: return S_POLL_A;
      S_CHK_B: return S_POLL_B;
      default: return S_POLL_Y;
    endcase
  endfunction

endpackage

// File: rtl/dut_port_arb.sv
// Drives the DUT write/read ports from FSM requests; write wins so the two
// enables are never high together. Reports handshake fires back to the FSM.
module dut_port_arb #(
  parameter int ADDR_W = 3
) (
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_dat,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              write_rdy,
  input  logic              read_rdy,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_address,
  output logic              wr_fire,
  output logic              rd_fire
);

  assign write_en      = wr_req;
  assign write_address = wr_req ? wr_addr : '0;
  assign write_data    = wr_req & wr_dat;
  assign read_en       = rd_req & ~wr_req;
  assign read_address  = read_en ? rd_addr : '0;
  assign wr_fire       = write_en & write_rdy;
  assign rd_fire       = read_en & read_rdy;

endmodule

// File: rtl/dut_host_sequencer.sv
// Host-side sequencer: write A, write B, poll Y, read Y, one transaction at a time.
// Optional poll timeout enabled with `define SEQ_TIMEOUT_EN.
module dut_host_sequencer
  import dut_host_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_a,
  input  logic              op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_y,
  output logic              res_err,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_data,
  output logic              write_en,
  input  logic              write_rdy,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_en,
  input  logic              read_data,
  input  logic              read_rdy
);

  if (2**CNT_W <= TIMEOUT_CYC) begin : g_cfg_err
    $error("CNT_W too narrow for TIMEOUT_CYC");
  end

  state_e state_q, state_d;
  logic a_q, a_d, b_q, b_d;
  logic op_ready_q, op_ready_d;
  logic res_valid_q, res_valid_d, res_y_q, res_y_d;
  logic wr_req, rd_req, wr_dat, wr_fire, rd_fire;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
`ifdef SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d, res_err_q, res_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    wr_req      = 1'b0;
    rd_req      = 1'b0;
    wr_dat      = 1'b0;
    wr_addr     = '0;
    rd_addr     = '0;
`ifdef SEQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      S_IDLE: if (op_valid && op_ready_q) begin
        a_d     = op_a;
        b_d     = op_b;
        state_d = S_POLL_A;
`ifdef SEQ_TIMEOUT_EN
        cnt_d   = '0;
        to_d    = 1'b0;
`endif
      end
      S_POLL_A: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(ADDR_A_NF);
        if (rd_fire) state_d = S_CHK_A;
      end
      S_POLL_B: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(ADDR_B_NF);
        if (rd_fire) state_d = S_CHK_B;
      end
      S_POLL_Y: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(ADDR_Y_NE);
        if (rd_fire) state_d = S_CHK_Y;
      end
      S_CHK_A, S_CHK_B, S_CHK_Y: begin
        if (read_data) state_d = chk_hit(state_q);
        else begin
`ifdef SEQ_TIMEOUT_EN
          // Give up on this transaction and report an error result instead.
          if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            state_d = S_CAP_Y;
            to_d    = 1'b1;
          end else begin
            state_d = chk_retry(state_q);
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
`else
          state_d = chk_retry(state_q);
`endif
        end
      end
      S_WR_A: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_W'(ADDR_A_WR);
        wr_dat  = a_q;
        if (wr_fire) begin
          state_d = S_POLL_B;
`ifdef SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WR_B: begin
        wr_req  = 1'b1;
        wr_addr = ADDR_W'(ADDR_B_WR);
        wr_dat  = b_q;
        if (wr_fire) begin
          state_d = S_POLL_Y;
`ifdef SEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_RD_Y: begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(ADDR_Y_RD);
        if (rd_fire) state_d = S_CAP_Y;
      end
      S_CAP_Y: begin
`ifdef SEQ_TIMEOUT_EN
        res_y_d   = read_data & ~to_q;
        res_err_d = to_q;
`else
        res_y_d   = read_data;
`endif
        res_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: if (res_ready) begin
        res_valid_d = 1'b0;
        res_y_d     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        res_err_d   = 1'b0;
`endif
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    op_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q       <= '0;
      to_q        <= 1'b0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
`ifdef SEQ_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

  dut_port_arb #(.ADDR_W(ADDR_W)) u_arb (
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .write_rdy(write_rdy), .read_rdy(read_rdy),
    .write_en(write_en), .write_address(write_address), .write_data(write_data),
    .read_en(read_en), .read_address(read_address),
    .wr_fire(wr_fire), .rd_fire(rd_fire)
  );

endmodule
